// File: rtl/core_mem_pkg.sv
// rtl/core_mem_pkg.sv - shared types and defaults for the RV32I memory scheduler
package core_mem_pkg;

  typedef enum logic [1:0] {PORT_NONE, PORT_LSU, PORT_FETCH, PORT_DEBUG} port_e;

  localparam int STARVE_MAX_DEFAULT = 8;
  localparam int STARVE_W           = 8;

endpackage

// File: rtl/core_starve_counter.sv
// rtl/core_starve_counter.sv - saturating lost-cycle counter that flags a starved requester
module core_starve_counter
  import core_mem_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clk_en,
  input  logic i_waiting,
  input  logic i_granted,
  output logic o_starved
);

  localparam logic [STARVE_W-1:0] MAX_C = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] cnt_q, cnt_d;

  // Dropping the request forfeits any accumulated seniority.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clk_en) begin
      if (!i_waiting || i_granted) begin
        cnt_d = '0;
      end else if (cnt_q != MAX_C) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_starved = (cnt_q == MAX_C);

endmodule

// File: rtl/core_mem_sched.sv
// rtl/core_mem_sched.sv - shares one 1-cycle-latency memory port among LSU, fetch and debug
module core_mem_sched
  import core_mem_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_clk_en,
  output logic            o_stall,
  input  logic            i_fetch_req,
  output logic            o_fetch_gnt,
  input  logic [AW-1:0]   i_fetch_addr,
  output logic [DW-1:0]   o_fetch_rdata,
  output logic            o_fetch_ack,
  input  logic            i_lsu_req,
  input  logic            i_lsu_we,
  input  logic [AW-1:0]   i_lsu_addr,
  input  logic [DW/8-1:0] i_lsu_be,
  input  logic [DW-1:0]   i_lsu_wdata,
  output logic            o_lsu_gnt,
  output logic            o_lsu_ack,
  output logic [DW-1:0]   o_lsu_rdata,
  input  logic            i_dbg_req,
  input  logic            i_dbg_we,
  input  logic [AW-1:0]   i_dbg_addr,
  input  logic [DW/8-1:0] i_dbg_be,
  input  logic [DW-1:0]   i_dbg_wdata,
  output logic            o_dbg_gnt,
  output logic            o_dbg_ack,
  output logic [DW-1:0]   o_dbg_rdata,
  output logic            o_mem_en,
  output logic            o_mem_we,
  output logic [AW-1:0]   o_mem_addr,
  output logic [DW/8-1:0] o_mem_be,
  output logic [DW-1:0]   o_mem_wdata,
  input  logic [DW-1:0]   i_mem_rdata
);

  if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve_max
    $fatal(1, "core_mem_sched: STARVE_MAX must be in 1..255");
  end

  port_e win;
  port_e owner_q, owner_d;
  logic  rd_q, rd_d;
  logic  fetch_starved, dbg_starved;

  core_starve_counter #(.STARVE_MAX(STARVE_MAX)) u_fetch_starve (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clk_en  (i_clk_en),
    .i_waiting (i_fetch_req),
    .i_granted (o_fetch_gnt),
    .o_starved (fetch_starved)
  );

  core_starve_counter #(.STARVE_MAX(STARVE_MAX)) u_dbg_starve (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clk_en  (i_clk_en),
    .i_waiting (i_dbg_req),
    .i_granted (o_dbg_gnt),
    .o_starved (dbg_starved)
  );

  // Starved requesters jump ahead of LSU; fetch beats debug when both are starved.
  always_comb begin
    win = PORT_NONE;
    if (i_clk_en) begin
      if (i_fetch_req && fetch_starved)    win = PORT_FETCH;
      else if (i_dbg_req && dbg_starved)   win = PORT_DEBUG;
      else if (i_lsu_req)                  win = PORT_LSU;
      else if (i_fetch_req)                win = PORT_FETCH;
      else if (i_dbg_req)                  win = PORT_DEBUG;
    end
  end

  assign o_lsu_gnt   = (win == PORT_LSU);
  assign o_fetch_gnt = (win == PORT_FETCH);
  assign o_dbg_gnt   = (win == PORT_DEBUG);
  assign o_mem_en    = (win != PORT_NONE);

  always_comb begin
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_be    = '0;
    o_mem_wdata = '0;
    case (win)
      PORT_LSU: begin
        o_mem_we    = i_lsu_we;
        o_mem_addr  = i_lsu_addr;
        o_mem_be    = i_lsu_be;
        o_mem_wdata = i_lsu_wdata;
      end
      PORT_FETCH: begin
        o_mem_addr  = i_fetch_addr;
        o_mem_be    = '1;
      end
      PORT_DEBUG: begin
        o_mem_we    = i_dbg_we;
        o_mem_addr  = i_dbg_addr;
        o_mem_be    = i_dbg_be;
        o_mem_wdata = i_dbg_wdata;
      end
      default: ;
    endcase
  end

  assign owner_d = i_clk_en ? win : owner_q;
  assign rd_d    = i_clk_en ? (o_mem_en && !o_mem_we) : rd_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      owner_q <= PORT_NONE;
      rd_q    <= 1'b0;
    end else begin
      owner_q <= owner_d;
      rd_q    <= rd_d;
    end
  end

  assign o_lsu_ack     = (owner_q == PORT_LSU);
  assign o_fetch_ack   = (owner_q == PORT_FETCH);
  assign o_dbg_ack     = (owner_q == PORT_DEBUG);
  assign o_lsu_rdata   = (o_lsu_ack && rd_q)   ? i_mem_rdata : '0;
  assign o_fetch_rdata = (o_fetch_ack && rd_q) ? i_mem_rdata : '0;
  assign o_dbg_rdata   = (o_dbg_ack && rd_q)   ? i_mem_rdata : '0;

  assign o_stall = (i_fetch_req && !o_fetch_gnt) || (i_lsu_req && !o_lsu_gnt);

endmodule

// File: tb/tb_core_mem_sched.sv
// tb/tb_core_mem_sched.sv - scoreboard bench for core_mem_sched with a priority/starvation model
module tb_core_mem_sched;
  import core_mem_pkg::*;

  localparam int SM  = 8;
  localparam int LSU = 0, FET = 1, DBG = 2, NON = 3;

  logic        i_clk = 1'b0;
  logic        i_rst, i_clk_en, o_stall;
  logic        i_fetch_req, o_fetch_gnt, o_fetch_ack;
  logic [31:0] i_fetch_addr, o_fetch_rdata;
  logic        i_lsu_req, i_lsu_we, o_lsu_gnt, o_lsu_ack;
  logic [31:0] i_lsu_addr, i_lsu_wdata, o_lsu_rdata;
  logic [3:0]  i_lsu_be;
  logic        i_dbg_req, i_dbg_we, o_dbg_gnt, o_dbg_ack;
  logic [31:0] i_dbg_addr, i_dbg_wdata, o_dbg_rdata;
  logic [3:0]  i_dbg_be;
  logic        o_mem_en, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic [31:0] i_mem_rdata = 32'h0;

  always #5 i_clk = ~i_clk;

  core_mem_sched #(.AW(32), .DW(32), .STARVE_MAX(SM)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_clk_en(i_clk_en), .o_stall(o_stall),
    .i_fetch_req(i_fetch_req), .o_fetch_gnt(o_fetch_gnt), .i_fetch_addr(i_fetch_addr),
    .o_fetch_rdata(o_fetch_rdata), .o_fetch_ack(o_fetch_ack),
    .i_lsu_req(i_lsu_req), .i_lsu_we(i_lsu_we), .i_lsu_addr(i_lsu_addr), .i_lsu_be(i_lsu_be),
    .i_lsu_wdata(i_lsu_wdata), .o_lsu_gnt(o_lsu_gnt), .o_lsu_ack(o_lsu_ack), .o_lsu_rdata(o_lsu_rdata),
    .i_dbg_req(i_dbg_req), .i_dbg_we(i_dbg_we), .i_dbg_addr(i_dbg_addr), .i_dbg_be(i_dbg_be),
    .i_dbg_wdata(i_dbg_wdata), .o_dbg_gnt(o_dbg_gnt), .o_dbg_ack(o_dbg_ack), .o_dbg_rdata(o_dbg_rdata),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_be(o_mem_be),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
  );

  typedef struct { int port; logic [31:0] data; } exp_t;

  int          n_chk = 0, n_fail = 0;
  exp_t        sbq[$];
  logic [31:0] mem [16];
  bit          act [3];
  bit          we  [3];
  logic [31:0] addr[3];
  logic [3:0]  be  [3];
  logic [31:0] wd  [3];
  int          cf = 0, cd = 0;

  task automatic chk(string name, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, a, e, $time);
    end
  endtask

  // External 16-word memory with one-cycle read latency.
  always @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h5A00_0000 + 32'(i) * 32'h0001_0203;
      mem[0] <= 32'hDEAD_BEEF;
    end else if (i_clk_en && o_mem_en) begin
      if (o_mem_we) begin
        for (int b = 0; b < 4; b++)
          if (o_mem_be[b]) mem[o_mem_addr[5:2]][8*b +: 8] <= o_mem_wdata[8*b +: 8];
      end else begin
        i_mem_rdata <= mem[o_mem_addr[5:2]];
      end
    end
  end

  task automatic drive();
    i_lsu_req = act[LSU]; i_lsu_we = we[LSU]; i_lsu_addr = addr[LSU];
    i_lsu_be = be[LSU]; i_lsu_wdata = wd[LSU];
    i_fetch_req = act[FET]; i_fetch_addr = addr[FET];
    i_dbg_req = act[DBG]; i_dbg_we = we[DBG]; i_dbg_addr = addr[DBG];
    i_dbg_be = be[DBG]; i_dbg_wdata = wd[DBG];
  endtask

  // One cycle: called at a negedge, returns at the next negedge.
  task automatic step();
    int w; bit en, ewe; logic [31:0] ea, ewd; logic [3:0] ebe;
    drive();
    #1;
    en = i_clk_en;
    w  = NON;
    if (en) begin
      if (act[FET] && cf == SM)      w = FET;
      else if (act[DBG] && cd == SM) w = DBG;
      else if (act[LSU])             w = LSU;
      else if (act[FET])             w = FET;
      else if (act[DBG])             w = DBG;
    end
    chk("lsu_gnt", o_lsu_gnt, w == LSU);
    chk("fetch_gnt", o_fetch_gnt, w == FET);
    chk("dbg_gnt", o_dbg_gnt, w == DBG);
    chk("mem_en", o_mem_en, w != NON);
    if (w == NON) begin
      ea = 0; ewe = 0; ebe = 0; ewd = 0;
    end else begin
      ea  = addr[w];
      ewe = (w == FET) ? 1'b0 : we[w];
      ebe = (w == FET) ? 4'hF : be[w];
      ewd = (w == FET) ? 32'h0 : wd[w];
    end
    chk("mem_addr", o_mem_addr, ea);
    chk("mem_we", o_mem_we, ewe);
    chk("mem_be", o_mem_be, ebe);
    chk("mem_wdata", o_mem_wdata, ewd);
    chk("stall", o_stall, (act[FET] && w != FET) || (act[LSU] && w != LSU));
    if (w != NON) sbq.push_back('{port: w, data: (ewe ? 32'h0 : mem[ea[5:2]])});
    @(posedge i_clk);
    if (en) begin
      cf = (!act[FET] || w == FET) ? 0 : ((cf < SM) ? cf + 1 : cf);
      cd = (!act[DBG] || w == DBG) ? 0 : ((cd < SM) ? cd + 1 : cd);
    end
    if (w != NON) act[w] = 0;
    @(negedge i_clk);
  endtask

  task automatic arm(int p, bit w_, logic [31:0] a, logic [3:0] b, logic [31:0] d);
    act[p] = 1; we[p] = w_; addr[p] = a; be[p] = b; wd[p] = d;
  endtask

  initial begin : monitor
    logic [2:0] last, a;
    bit en;
    exp_t e;
    last = 3'b000;
    forever begin
      @(posedge i_clk);
      en = i_clk_en;
      #2;
      a = {o_dbg_ack, o_fetch_ack, o_lsu_ack};
      if (!i_rst) begin
        if (!en) begin
          chk("ack_hold", a, last);
        end else if (a == 3'b000) begin
          chk("missing_ack", sbq.size(), 0);
          if (sbq.size() != 0) sbq.delete(0);
          chk("idle_rdata", o_lsu_rdata | o_fetch_rdata | o_dbg_rdata, 0);
        end else begin
          chk("one_ack", $countones(a), 1);
          if (sbq.size() == 0) begin
            chk("unexpected_ack", a, 0);
          end else begin
            e = sbq.pop_front();
            chk("ack_port", a, 3'b001 << e.port);
            chk("lsu_rdata", o_lsu_rdata, (e.port == LSU) ? e.data : 32'h0);
            chk("fetch_rdata", o_fetch_rdata, (e.port == FET) ? e.data : 32'h0);
            chk("dbg_rdata", o_dbg_rdata, (e.port == DBG) ? e.data : 32'h0);
          end
        end
      end
      last = a;
    end
  end

  initial begin : stim
    bit g;
    int n;
    i_rst = 1; i_clk_en = 1;
    for (int p = 0; p < 3; p++) begin
      act[p] = 0; we[p] = 0; addr[p] = 0; be[p] = 0; wd[p] = 0;
    end
    drive();
    repeat (3) @(negedge i_clk);
    i_rst = 0;
    step();
    chk("rst_acks", {o_dbg_ack, o_fetch_ack, o_lsu_ack}, 0);
    chk("rst_rdata", o_lsu_rdata | o_fetch_rdata | o_dbg_rdata, 0);
    chk("rst_stall", o_stall, 0);

    arm(LSU, 0, 32'h100, 4'hF, 32'h0);
    step();
    chk("lsu_ack_n1", o_lsu_ack, 1);
    chk("lsu_rdata_deadbeef", o_lsu_rdata, 32'hDEAD_BEEF);
    chk("fetch_ack_quiet", o_fetch_ack, 0);

    arm(LSU, 0, 32'h104, 4'hF, 32'h0);
    arm(FET, 0, 32'h008, 4'hF, 32'h0);
    step();
    step();
    step();

    arm(DBG, 1, 32'h40, 4'b0011, 32'h1234_5678);
    step();
    chk("dbg_ack", o_dbg_ack, 1);
    chk("dbg_write_rdata", o_dbg_rdata, 0);

    // Build up starvation counts, win a fetch, then reset before the response edge.
    arm(FET, 0, 32'h0C, 4'hF, 32'h0);
    arm(DBG, 0, 32'h18, 4'hF, 32'h0);
    repeat (3) begin
      arm(LSU, 0, 32'h20, 4'hF, 32'h0);
      step();
    end
    drive();
    #1;
    chk("fetch_gnt_pre_rst", o_fetch_gnt, 1);
    #1;
    i_rst = 1;
    for (int p = 0; p < 3; p++) act[p] = 0;
    drive();
    #1;
    i_rst = 0;
    cf = 0; cd = 0;
    @(negedge i_clk);
    chk("no_ack_after_rst", o_fetch_ack, 0);

    arm(FET, 0, 32'h24, 4'hF, 32'h0);
    n = 0;
    do begin
      arm(LSU, 1'($urandom_range(0, 1)), $urandom & 32'hFC, 4'($urandom), $urandom);
      drive();
      #1;
      g = o_fetch_gnt;
      step();
      n++;
    end while (!g && n < 20);
    chk("starve_grant_cycle", n, SM + 1);
    act[LSU] = 0;
    step();

    i_clk_en = 0;
    arm(LSU, 0, 32'h30, 4'hF, 32'h0);
    repeat (3) step();
    i_clk_en = 1;
    step();
    step();

    repeat (800) begin
      i_clk_en = ($urandom_range(0, 9) != 0);
      for (int p = 0; p < 3; p++) begin
        if (!act[p]) begin
          if ($urandom_range(0, 99) < ((p == LSU) ? 75 : 35))
            arm(p, (p == FET) ? 1'b0 : 1'($urandom_range(0, 1)),
                $urandom & 32'hFFFF_FFFC, 4'($urandom), $urandom);
        end else if ($urandom_range(0, 99) < 3) begin
          act[p] = 0;
        end
      end
      step();
    end

    i_clk_en = 1;
    for (int p = 0; p < 3; p++) act[p] = 0;
    repeat (3) step();
    chk("sb_drain", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/core_mem_sched.md
# core_mem_sched

Single-port memory scheduler for the RV32I core. Shares one synchronous, one-cycle-read-latency memory port between three requesters: instruction fetch, LSU and debug. Uses fixed priority (LSU > fetch > debug) with per-requester starvation guards. Issues at most one access per enabled cycle and routes each response back to its owner one cycle later, so throughput is one access per cycle.

## Interface
- AW, 32, address width
- DW, 32, data width (byte enables are DW/8 wide)
- STARVE_MAX, 8, consecutive lost cycles (range 1..255) after which fetch or debug is promoted to top priority
- i_clk  in  1  clock
- i_rst  in  1  reset; asynchronous, active-high
- i_clk_en  in  1  global clock enable; when low the block is frozen
- o_stall  out  1  core stall request
- i_fetch_req / o_fetch_gnt  in/out  1  fetch read request / grant
- i_fetch_addr  in  AW  fetch address
- o_fetch_rdata / o_fetch_ack  out  DW / 1  read data / response valid
- i_lsu_req, i_lsu_we  in  1  LSU request and write select
- i_lsu_addr, i_lsu_be, i_lsu_wdata  in  AW, DW/8, DW  LSU command
- o_lsu_gnt, o_lsu_ack  out  1  LSU grant / response valid
- o_lsu_rdata  out  DW  LSU read data
- i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_be, i_dbg_wdata  in  same as LSU  debug command
- o_dbg_gnt, o_dbg_ack, o_dbg_rdata  out  1, 1, DW  debug grant / response valid / read data
- o_mem_en, o_mem_we  out  1  memory command valid / write
- o_mem_addr, o_mem_be, o_mem_wdata  out  AW, DW/8, DW  memory command
- i_mem_rdata  in  DW  memory read data, valid the enabled cycle after o_mem_en with o_mem_we=0

## Operation
- Handshake: a requester raises req with its payload and holds both stable until it sees gnt high on a rising edge. Transfer occurs on the edge where req and gnt are both high. It may then drop req or present the next command in the next cycle.
- Grants are combinational from current reqs and starvation state. At most one gnt is high per cycle. No gnt is issued while i_clk_en=0.
- o_mem_* are combinational from the winner's payload. With no winner: o_mem_en=0 and the other o_mem_* are 0.
- Fetch has no we/be ports: it always issues a read with be all ones.
- Base priority is LSU, then fetch, then debug.
- Starvation counters (fetch, debug):
  - A counter increments, saturating at STARVE_MAX, on each enabled cycle its owner has req high without gnt.
  - It clears on grant or on any enabled cycle with req low.
  - At count==STARVE_MAX the owner outranks LSU.
  - If both are starved, fetch wins.
- Response routing: a registered owner tag (PORT_NONE/LSU/FETCH/DEBUG) captures the winner on each enabled edge. The matching o_*_ack is high for exactly the following enabled cycle. Writes are acked the same way.
- rdata: o_*_rdata equals i_mem_rdata when that port's ack is high and the access was a read. Otherwise o_*_rdata is 0.
- o_stall = (i_fetch_req & ~o_fetch_gnt) | (i_lsu_req & ~o_lsu_gnt). Debug never stalls the core.

## Timing
- Reset (asynchronous assert): owner tag = PORT_NONE, all acks 0, both counters 0. All rdata outputs therefore read 0. gnt and o_mem_en are 0 whenever no req is high.
- Latency: grant is in cycle N; ack and rdata are in cycle N+1. Back-to-back grants are permitted, so a new grant at N+1 coincides with the ack for N.
- i_clk_en low: tag, acks and counters hold their values; gnt and o_mem_en are 0. o_stall still reflects pending fetch/LSU reqs.
- Simultaneous requests: exactly one gnt, following the priority rules. Losers keep req asserted, and their counters advance.
- A requester that drops req before grant loses its place with no side effect, and its counter clears.
- Reset asserted mid-access: the pending ack is discarded and no ack is issued after reset release.
- Counter width is 8 bits. STARVE_MAX outside 1..255 is a parameter error; elaboration fails via an assertion.

## Structure
- Package core_mem_pkg holds:
  - typedef enum logic [1:0] port_e {PORT_NONE, PORT_LSU, PORT_FETCH, PORT_DEBUG}
  - the localparam for the default STARVE_MAX
- Sub-module core_starve_counter: an 8-bit saturating counter with inputs waiting, granted and clk_en, and a starved output. It is instantiated twice, for fetch and debug.
- Grant logic, the mem mux and the response demux stay in core_mem_sched.

## Test plan
- Reset then idle → all acks 0, o_mem_en 0, o_stall 0, all rdata 0.
- LSU read at 0x100 with memory returning 0xDEADBEEF → o_lsu_gnt at N, o_lsu_ack with o_lsu_rdata=0xDEADBEEF at N+1, o_fetch_ack=0.
- LSU and fetch request in the same cycle → LSU granted first and fetch granted the next cycle. o_stall=1 in the first cycle and 0 in the second.
- LSU held continuously plus fetch, STARVE_MAX=8 → fetch granted on its 9th requesting cycle, and LSU stalls for that one cycle.
- Debug write of 0x12345678 with be=4'b0011 to 0x40 → o_mem_we=1 and o_mem_be=0011, o_dbg_ack=1 and o_dbg_rdata=0 next cycle, o_stall=0 throughout.
- Fetch granted, then i_rst pulsed asynchronously before the next edge → no o_fetch_ack, counters 0. Then i_clk_en held low for 3 cycles with LSU requesting → no gnt, o_stall=1.
